mips_prog_loader: RTL and testbench
===================================

// Module: mips_prog_loader
// PURPOSE
//  Writer side of the processor instruction memory. It accepts a stream of 32-bit
//  instruction words over a valid/ready handshake and writes them to consecutive
//  memory addresses. It then clears the processor PC and releases the processor to
//  run. It reports done when the processor signals HLT. Sits between the host/debug
//  link and the instruction memory write port / processor run control.
// PARAMETERS
//  AW          10     memory address width
//  DEPTH       1024   max words per program (DEPTH <= 2**AW)
//  BASE_ADDR   0      address of first word written
//  REQUIRE_HLT 1      1: program lacking an HLT word is rejected
//  HLT_OPC     6'h3f  opcode field [31:26] identifying HLT
// PORTS
//  clk1        in   1     single clock, all state on rising edge
//  rst_n       in   1     asynchronous, active-low reset
//  load_req    in   1     start a load session (sampled in IDLE/DONE/ERR only)
//  in_valid    in   1     instruction word valid
//  in_ready    out  1     loader can accept a word
//  in_data     in   32    instruction word
//  in_last     in   1     qualifies final word of program
//  mem_we      out  1     instruction memory write enable
//  mem_addr    out  AW    write address
//  mem_wdata   out  32    write data
//  cpu_pc_clr  out  1     one-cycle pulse: processor PC <= 0
//  cpu_run     out  1     level; 0 holds processor halted
//  cpu_halted  in   1     processor has executed HLT
//  busy        out  1     state is LOAD, START or RUN
//  done        out  1     program ran to HLT
//  err         out  1     session rejected (overflow / missing HLT)
//  word_count  out  AW+1  words accepted this session
//  checksum    out  32    mod-2**32 sum of words accepted this session
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters/flags cleared; effective immediately.
//  Reset mid-session aborts; partially written memory is left as is.
//  States: IDLE, LOAD, START, RUN, DONE, ERR.
//   IDLE/DONE/ERR + load_req -> LOAD. On this transition: clear word_count,
//     checksum, done, err and the hlt_seen flag; set the write pointer to BASE_ADDR.
//     Other inputs are ignored in IDLE/DONE/ERR.
//   LOAD: in_ready = (word_count < DEPTH). A word is accepted when in_valid & in_ready.
//   Accept at cycle N -> at cycle N+1:
//     mem_we=1, mem_addr=pointer, mem_wdata=word;
//     word_count+1 and checksum+word, both registered;
//     pointer+1, wrapping mod 2**AW;
//     hlt_seen set if word[31:26]==HLT_OPC.
//   mem_we is low in every other cycle.
//   LOAD, in_valid & word_count==DEPTH -> ERR (overflow). The word is not written.
//   LOAD, accepted word with in_last=1:
//     -> ERR if REQUIRE_HLT & !hlt_seen, where hlt_seen includes the last word itself;
//     -> START otherwise.
//   START (1 cycle): cpu_pc_clr=1, cpu_run=0. The final mem_we occurs in this cycle.
//     -> RUN.
//   RUN: cpu_run=1, in_ready=0; load_req ignored. cpu_halted=1 -> DONE, and
//     cpu_run=0 from the next cycle.
//   DONE: done=1 (level) until next load_req. ERR: err=1 (level) until next load_req.
//   cpu_halted is ignored outside RUN. in_last is ignored unless the word is accepted.
//   Outputs in_ready, cpu_run, cpu_pc_clr, busy, done and err are registered
//   from state (no input-to-output combinational paths).
// TESTING
//  T1 Load Mem[0..8] program:
//     2801000a,28020014,28030019,0ce77800,0ce77800,00222000,0ce77800,00832800,
//     fc000000 (last).
//     -> 9 mem_we pulses at addr 0..8; word_count=9; cpu_pc_clr one cycle;
//        cpu_run high next cycle.
//     Then cpu_halted=1 -> done=1, cpu_run=0.
//  T2 Same program with in_valid toggling every other cycle
//     -> writes only on handshake cycles; addresses contiguous 0..8;
//        final memory image identical to T1.
//  T3 DEPTH=4, five words, no in_last -> after 4 writes in_ready=0;
//     5th valid -> err=1; no 5th mem_we; cpu_run stays 0.
//  T4 Words 2801000a, 00222000 (last), no HLT -> err=1, no cpu_pc_clr.
//     With REQUIRE_HLT=0 -> START/RUN entered instead.
//  T5 Words 2801000a, 28020014, fc000000 -> checksum=32'h4c03001e (wrapped), word_count=3.
//  T6 Assert rst_n=0 after 3 accepted words -> all outputs 0 immediately.
//     After release: state IDLE; in_valid ignored until load_req.

Source files
------------

// File: rtl/mips_prog_loader.sv
// Instruction memory loader: streams words into memory, then releases the
// processor from a cleared PC and reports done when it halts.
module mips_prog_loader #(
  parameter int          AW          = 10,
  parameter int          DEPTH       = 1024,
  parameter int          BASE_ADDR   = 0,
  parameter bit          REQUIRE_HLT = 1'b1,
  parameter logic [5:0]  HLT_OPC     = 6'h3f
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          load_req,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_pc_clr,
  output logic          cpu_run,
  input  logic          cpu_halted,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   word_count,
  output logic [31:0]   checksum
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] BASE_W  = AW'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic          hlt_seen;
  logic          accept;
  logic          hlt_now;
  logic          start;

  // Status outputs decode directly from registered state/count only.
  assign in_ready   = (state == S_LOAD) && (word_count < DEPTH_W);
  assign cpu_pc_clr = (state == S_START);
  assign cpu_run    = (state == S_RUN);
  assign busy       = (state == S_LOAD) || (state == S_START) || (state == S_RUN);
  assign done       = (state == S_DONE);
  assign err        = (state == S_ERR);

  assign accept  = in_ready && in_valid;
  // HLT check includes the word being accepted right now.
  assign hlt_now = hlt_seen || (in_data[31:26] == HLT_OPC);
  assign start   = load_req &&
                   ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  // State register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (load_req) state_nxt = S_LOAD;
      S_LOAD: begin
        if (in_valid && (word_count == DEPTH_W))
          state_nxt = S_ERR;
        else if (accept && in_last)
          state_nxt = (REQUIRE_HLT && !hlt_now) ? S_ERR : S_START;
      end
      S_START: state_nxt = S_RUN;
      S_RUN:   if (cpu_halted) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write port, pointer, counters and HLT tracking; writes land one cycle after accept.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ptr        <= BASE_W;
      word_count <= '0;
      checksum   <= '0;
      hlt_seen   <= 1'b0;
    end else begin
      mem_we <= accept;
      if (start) begin
        ptr        <= BASE_W;
        word_count <= '0;
        checksum   <= '0;
        hlt_seen   <= 1'b0;
      end else if (accept) begin
        mem_addr   <= ptr;
        mem_wdata  <= in_data;
        ptr        <= ptr + 1'b1;
        word_count <= word_count + 1'b1;
        checksum   <= checksum + in_data;
        hlt_seen   <= hlt_now;
      end
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized bench for mips_prog_loader: three configurations (default,
// DEPTH=4, REQUIRE_HLT=0) checked against a program-level outcome model.
module tb_mips_prog_loader;
  localparam int AW = 10;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic          rst_n;
  logic          load_req [3];
  logic          in_valid [3];
  logic          in_last  [3];
  logic          cpu_halted [3];
  logic [31:0]   in_data  [3];
  logic          in_ready [3];
  logic          mem_we   [3];
  logic          cpu_pc_clr [3];
  logic          cpu_run  [3];
  logic          busy     [3];
  logic          done     [3];
  logic          err      [3];
  logic [AW-1:0] mem_addr [3];
  logic [31:0]   mem_wdata [3];
  logic [31:0]   checksum [3];
  logic [AW:0]   word_count [3];

  int dep [3] = '{1024, 4, 1024};
  bit req [3] = '{1'b1, 1'b1, 1'b0};

  mips_prog_loader #(.AW(AW)) u_dut0 (
    .clk1(clk1), .rst_n(rst_n), .load_req(load_req[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .cpu_pc_clr(cpu_pc_clr[0]), .cpu_run(cpu_run[0]), .cpu_halted(cpu_halted[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]),
    .word_count(word_count[0]), .checksum(checksum[0]));

  mips_prog_loader #(.AW(AW), .DEPTH(4)) u_dut1 (
    .clk1(clk1), .rst_n(rst_n), .load_req(load_req[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .cpu_pc_clr(cpu_pc_clr[1]), .cpu_run(cpu_run[1]), .cpu_halted(cpu_halted[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]),
    .word_count(word_count[1]), .checksum(checksum[1]));

  mips_prog_loader #(.AW(AW), .REQUIRE_HLT(1'b0)) u_dut2 (
    .clk1(clk1), .rst_n(rst_n), .load_req(load_req[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .in_data(in_data[2]), .in_last(in_last[2]),
    .mem_we(mem_we[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
    .cpu_pc_clr(cpu_pc_clr[2]), .cpu_run(cpu_run[2]), .cpu_halted(cpu_halted[2]),
    .busy(busy[2]), .done(done[2]), .err(err[2]),
    .word_count(word_count[2]), .checksum(checksum[2]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write/start monitor for the instance currently under test.
  int          cur    = 0;
  bit          mon_on = 1'b0;
  logic [41:0] wq [$];
  int          pcc    = 0;
  bit          prev_pc = 1'b0;

  always @(negedge clk1) begin
    if (mon_on) begin
      if (mem_we[cur]) wq.push_back({mem_addr[cur], mem_wdata[cur]});
      if (cpu_pc_clr[cur]) begin
        pcc++;
        chk("we_in_start", 64'(mem_we[cur]), 64'd1);
        chk("run_in_start", 64'(cpu_run[cur]), 64'd0);
      end
      if (prev_pc) chk("run_after_start", 64'(cpu_run[cur]), 64'd1);
      if (cpu_run[cur]) chk("ready_in_run", 64'(in_ready[cur]), 64'd0);
      prev_pc = cpu_pc_clr[cur];
    end else begin
      prev_pc = 1'b0;
    end
  end

  // One load session plus outcome check against the program-level model.
  task automatic run_prog(input int idx, input logic [31:0] w[$], input bit last_en,
                          input int vprob, input string tn);
    int n, k, budget, acc, base_w, base_p;
    bit hs, exp_err, has_hlt;
    logic [31:0] sum;
    logic [AW-1:0] ea;
    n = w.size(); k = 0; budget = 0;
    cur = idx; base_w = wq.size(); base_p = pcc; mon_on = 1'b1;
    @(posedge clk1); #1 load_req[idx] = 1'b1;
    @(posedge clk1); #1 load_req[idx] = 1'b0;
    while (k < n && budget < 400) begin
      in_valid[idx] = ($urandom_range(99) < vprob);
      in_data[idx]  = w[k];
      in_last[idx]  = last_en && (k == n-1);
      @(negedge clk1);
      hs = in_valid[idx] && in_ready[idx];
      @(posedge clk1); #1;
      budget++;
      if (hs) k++;
      if (err[idx]) break;
    end
    in_valid[idx] = 1'b0; in_last[idx] = 1'b0;
    chk({tn, "_feed_timeout"}, 64'(budget < 400), 64'd1);

    // Model: accepted words, checksum, and expected outcome.
    acc = (n <= dep[idx]) ? n : dep[idx];
    sum = '0; has_hlt = 1'b0;
    for (int j = 0; j < acc; j++) begin
      sum += w[j];
      if (w[j][31:26] == 6'h3f) has_hlt = 1'b1;
    end
    exp_err = (n > dep[idx]) || (req[idx] && !has_hlt);

    if (!exp_err) begin
      int t = 0;
      while (t < 10) begin
        @(negedge clk1);
        if (cpu_run[idx]) break;
        t++;
      end
      chk({tn, "_run_seen"}, 64'(cpu_run[idx]), 64'd1);
      repeat ($urandom_range(5)) @(posedge clk1);
      #1 cpu_halted[idx] = 1'b1;
      @(posedge clk1); #1 cpu_halted[idx] = 1'b0;
      @(negedge clk1);
      chk({tn, "_done"}, 64'({done[idx], err[idx], cpu_run[idx], busy[idx]}), 64'b1000);
    end else begin
      @(negedge clk1);
      chk({tn, "_err"}, 64'({done[idx], err[idx], cpu_run[idx], busy[idx]}), 64'b0100);
    end
    repeat (2) @(negedge clk1);
    chk({tn, "_nwr"}, 64'(wq.size() - base_w), 64'(acc));
    for (int j = 0; j < acc && base_w + j < wq.size(); j++) begin
      ea = AW'(j);
      chk({tn, "_wr"}, 64'(wq[base_w + j]), 64'({ea, w[j]}));
    end
    chk({tn, "_wc"}, 64'(word_count[idx]), 64'(acc));
    chk({tn, "_cks"}, 64'(checksum[idx]), 64'(sum));
    chk({tn, "_pcclr"}, 64'(pcc - base_p), exp_err ? 64'd0 : 64'd1);
    mon_on = 1'b0;
  endtask

  localparam logic [31:0] T1P [9] = '{32'h2801000a, 32'h28020014, 32'h28030019,
    32'h0ce77800, 32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

  initial begin
    logic [31:0] prog [$];
    logic [31:0] wv;
    int idx, n;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_req[i] = 0; in_valid[i] = 0; in_last[i] = 0; cpu_halted[i] = 0; in_data[i] = '0;
    end
    repeat (3) @(posedge clk1);
    #1;
    for (int i = 0; i < 3; i++)
      chk("reset_state", 64'({in_ready[i], mem_we[i], cpu_pc_clr[i], cpu_run[i], busy[i],
          done[i], err[i], word_count[i], checksum[i]}), 64'd0);
    rst_n = 1'b1;

    // T1 / T2: full-rate and throttled load of the reference program
    prog = {};
    for (int i = 0; i < 9; i++) prog.push_back(T1P[i]);
    run_prog(0, prog, 1'b1, 100, "t1");
    run_prog(0, prog, 1'b1, 50, "t2");

    // T3: overflow on the DEPTH=4 instance
    prog = {};
    for (int i = 0; i < 5; i++) prog.push_back(T1P[i]);
    run_prog(1, prog, 1'b0, 100, "t3");

    // T4: missing HLT rejected, accepted when not required
    prog = {32'h2801000a, 32'h00222000};
    run_prog(0, prog, 1'b1, 100, "t4a");
    run_prog(2, prog, 1'b1, 100, "t4b");

    // T5: checksum wraps
    prog = {32'h2801000a, 32'h28020014, 32'hfc000000};
    run_prog(0, prog, 1'b1, 80, "t5");
    chk("t5_cks_const", 64'(checksum[0]), 64'h4c03001e);
    chk("t5_wc_const", 64'(word_count[0]), 64'd3);

    // Random sessions across all three configurations
    for (int s = 0; s < 24; s++) begin
      idx = $urandom_range(2);
      n = (idx == 1) ? $urandom_range(7, 1) : $urandom_range(10, 1);
      prog = {};
      for (int j = 0; j < n; j++) begin
        wv = $urandom;
        if ($urandom_range(99) < 25) wv[31:26] = 6'h3f;
        prog.push_back(wv);
      end
      run_prog(idx, prog, (n <= dep[idx]), $urandom_range(100, 30), "rnd");
    end

    // T6: reset mid-session, then inputs ignored until load_req
    @(posedge clk1); #1 load_req[0] = 1'b1;
    @(posedge clk1); #1 load_req[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      in_valid[0] = 1'b1; in_data[0] = $urandom; in_last[0] = 1'b0;
      @(negedge clk1);
      if (in_ready[0]) n++;
      @(posedge clk1); #1;
    end
    chk("t6_three_acc", 64'(n), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl", 64'({in_ready[0], mem_we[0], cpu_pc_clr[0], cpu_run[0], busy[0],
        done[0], err[0], word_count[0], checksum[0]}), 64'd0);
    chk("t6_rst_mem", 64'({mem_addr[0], mem_wdata[0]}), 64'd0);
    @(posedge clk1); #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid[0] = 1'b1; in_data[0] = $urandom; in_last[0] = c[0];
      @(negedge clk1);
      chk("t6_idle_ignore", 64'({in_ready[0], mem_we[0], busy[0], word_count[0]}), 64'd0);
      @(posedge clk1); #1;
    end
    in_valid[0] = 1'b0; in_last[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
